line_fill_responder: RTL and testbench

- Responder end of the instruction-cache line-fill bus. Accepts one line-fill request at a time from the i-cache miss path (REQ_BUS side) and reads the line from a synchronous backing word memory.
- Returns the line as a burst of WIDTH-bit beats, critical word first, wrapping within the line, with a valid/ready handshake and a last flag.
- Sits between the i-cache and the memory model; it is the block the cache's bus_respack/UPDATE_CACHE path waits on.

---
 rtl/mem_pkg.sv | 19 +
 rtl/resp_fifo.sv | 51 +++++
 rtl/line_fill_responder.sv | 107 ++++++++++
 tb/tb_line_fill_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the i-cache line-fill responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } resp_state_t;

  // Data returned on the single error beat of an out-of-range request.
  localparam logic [63:0] POISON = 64'hAAAA_AAAA_AAAA_AAAA;

  // Beats per line: line size in bits divided by beat width.
  function automatic int beats_f(input int offwidth, input int width);
    return ((2 ** offwidth) * 8) / width;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Two-entry return-data FIFO; each entry carries a beat plus its last flag.
module resp_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;

  // Occupancy next state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/line_fill_responder.sv
// Line-fill responder: reads a cache line critical-word-first from a
// synchronous word memory and returns it as a wrapped burst of beats.
module line_fill_responder
  import mem_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int OFFWIDTH = 6,
  parameter int MEMAW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_last,
  output logic             resp_err,
  output logic             mem_rd_en,
  output logic [MEMAW-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data
);

  localparam int BEATS = beats_f(OFFWIDTH, WIDTH);
  localparam int IDXW  = OFFWIDTH - 3;
  localparam int LBW   = MEMAW + 3 - OFFWIDTH;

  resp_state_t     state_q;
  logic [LBW-1:0]  line_base_q;
  logic [IDXW-1:0] start_q, issue_cnt_q, word_idx;
  logic            inflight_q, inflight_last_q;
  logic [WIDTH:0]  head;
  logic [1:0]      fifo_count;
  logic            fifo_empty, pop, issue, range_err, last_issue;
  logic [2:0]      occ;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^req_addr[2:0];
  assign range_err  = |req_addr[WIDTH-1:MEMAW+3];
  assign pop        = !fifo_empty && resp_ready;
  // Entries that will occupy the FIFO at the end of this cycle; a new read
  // lands one cycle later, so it is only safe while this is below two.
  assign occ        = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == READ) && (occ < 3'd2);
  assign last_issue = (issue_cnt_q == IDXW'(BEATS - 1));
  assign word_idx   = start_q + issue_cnt_q;

  assign req_ready   = (state_q == IDLE);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = {line_base_q, word_idx};
  assign resp_valid  = (state_q == ERR) || !fifo_empty;
  assign resp_err    = (state_q == ERR);
  assign resp_last   = (state_q == ERR) || (!fifo_empty && head[WIDTH]);
  assign resp_data   = (state_q == ERR) ? POISON[WIDTH-1:0] :
                       (fifo_empty ? '0 : head[WIDTH-1:0]);

  // Request capture, read sequencing and burst completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      line_base_q     <= '0;
      start_q         <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            line_base_q <= req_addr[MEMAW+2:OFFWIDTH];
            start_q     <= req_addr[OFFWIDTH-1:3];
            issue_cnt_q <= '0;
            state_q     <= range_err ? ERR : READ;
          end
        end
        READ: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
            if (last_issue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head[WIDTH]) state_q <= IDLE;
        end
        ERR: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  resp_fifo #(.W(WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   ({inflight_last_q, mem_rd_data}),
    .dout_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_line_fill_responder.sv
// Scoreboard bench for line_fill_responder.
module tb_line_fill_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [63:0] mem_rd_data = '0;

  typedef struct packed {
    logic        err;
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] addr_q[$];
  int          hs_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          issued = 0, popped = 0, rd_cnt = 0, pop_cnt = 0;
  int          hs_cyc = 0, bidx = 0;
  bit          timing_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] stall_data;
  logic        stall_last;

  line_fill_responder #(.WIDTH(64), .OFFWIDTH(6), .MEMAW(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_last   (resp_last),
    .resp_err    (resp_err),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: word k holds 0x1000+k, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 64'h1000 + 64'(mem_rd_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expected read addresses and beats for one request.
  task automatic expect_line(input logic [63:0] a);
    logic [12:0] lb;
    logic [2:0]  st, w;
    beat_t       e;
    lb = a[18:6];
    st = a[5:3];
    if (|a[63:19]) begin
      e.err = 1'b1; e.last = 1'b1; e.data = 64'hAAAAAAAAAAAAAAAA;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < 8; i++) begin
        w = st + 3'(i);
        addr_q.push_back({lb, w});
        e.err = 1'b0; e.last = (i == 7); e.data = 64'h1000 + 64'({lb, w});
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: scoreboard pops, read-address order, occupancy, stall stability.
  always @(negedge clk) begin
    logic  pop_now;
    beat_t e;
    if (!reset) begin
      exp_q.delete();
      addr_q.delete();
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end else begin
      pop_now = resp_valid && resp_ready;
      if (req_valid && req_ready) begin
        hs_q.push_back(cyc);
        hs_cyc = cyc;
        bidx = 0;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_data", resp_data, stall_data);
        check("hold_last", 64'(resp_last), 64'(stall_last));
      end
      prev_stall = resp_valid && !resp_ready;
      stall_data = resp_data;
      stall_last = resp_last;
      if (mem_rd_en) begin
        check("occupancy", 64'((issued - popped - int'(pop_now && !resp_err)) < 2), 64'd1);
        if (addr_q.size() == 0) check("rd_unexpected", 64'(mem_rd_addr), 64'hFFFF_FFFF);
        else check("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
        issued++;
        rd_cnt++;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) check("beat_unexpected", resp_data, 64'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("beat_data", resp_data, e.data);
          check("beat_last", 64'(resp_last), 64'(e.last));
          check("beat_err", 64'(resp_err), 64'(e.err));
        end
        if (timing_chk) check("beat_cycle", 64'(cyc - hs_cyc), 64'(3 + bidx));
        bidx++;
        pop_cnt++;
        if (!resp_err) popped++;
      end
      if (timing_chk && (cyc - hs_cyc) == 10) check("ready_c10", 64'(req_ready), 64'd0);
      if (timing_chk && (cyc - hs_cyc) == 11) check("ready_c11", 64'(req_ready), 64'd1);
    end
  end

  task automatic send(input logic [63:0] a);
    int n = 0;
    expect_line(a);
    @(posedge clk);
    #1;
    req_addr  = a;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      @(posedge clk);
      #1;
      if (bp) resp_ready = ((n % 4) == 0) || ((n % 4) == 3);
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'd0, 64'd1);
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n, rd0;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n, rd0;
    // Reset state, with a request pending that must not be latched.
    req_valid = 1'b1;
    req_addr  = 64'h40;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_last", 64'(resp_last), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(mem_rd_en), 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Aligned line with full-rate acceptance and cycle-exact timing.
    timing_chk = 1'b1;
    send(64'h40);
    drain(1'b0);

    // Critical word 7: wrapped order.
    send(64'h78);
    drain(1'b0);

    // Same request under backpressure.
    timing_chk = 1'b0;
    send(64'h78);
    drain(1'b1);

    // Out-of-range address: single poison beat, no memory reads.
    rd0 = rd_cnt;
    send(64'h0008_0000);
    drain(1'b0);
    check("err_no_reads", 64'(rd_cnt - rd0), 64'd0);

    // Reset in the middle of a burst after beat 3 is accepted.
    base = pop_cnt;
    send(64'h40);
    n = 0;
    while (pop_cnt < base + 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check("mid_rst_timeout", 64'd0, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_rd_en", 64'(mem_rd_en), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_beats", 64'(resp_valid), 64'd0);
    timing_chk = 1'b1;
    send(64'h80);
    drain(1'b0);

    // Back-to-back requests with req_valid held high.
    base = hs_q.size();
    expect_line(64'h40);
    expect_line(64'hC0);
    @(posedge clk);
    #1;
    req_addr  = 64'h40;
    req_valid = 1'b1;
    n = 0;
    while (hs_q.size() < base + 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    req_addr = 64'hC0;
    while (hs_q.size() < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    req_valid = 1'b0;
    if (n >= 200) check("b2b_timeout", 64'd0, 64'd1);
    drain(1'b0);
    if (hs_q.size() >= base + 2)
      check("b2b_gap", 64'(hs_q[base+1] - hs_q[base]), 64'd11);
    else
      check("b2b_handshakes", 64'(hs_q.size() - base), 64'd2);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
